spwm_param_ctrl: RTL and testbench

SPWM_PARAM_CTRL -- requirements
Module: spwm_param_ctrl

---
 rtl/spwm_param_ctrl.sv | 159 +++++++++++++++
 tb/tb_spwm_param_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spwm_param_ctrl.sv
// SPWM parameter controller: filters HPS configuration writes through a
// stability window, validates them, and ramps the modulating increment
// toward the accepted target one carrier period at a time.
module spwm_param_ctrl #(
  parameter int          STABLE_CYC = 16,
  parameter logic [31:0] RAMP_STEP  = 32'h0001_0000
) (
  input  logic        clk_clk,
  input  logic        reset,
  input  logic        enable_in,
  input  logic [31:0] freq_tri_in,
  input  logic [31:0] freq_sin_in,
  input  logic        tri_wrap,
  input  logic        err_clr,
  output logic        gen_enable,
  output logic [31:0] tri_inc,
  output logic [31:0] sin_inc,
  output logic        busy,
  output logic        cfg_err
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYC - 1);
  localparam logic [7:0] CNT_PRE = 8'(STABLE_CYC - 2);

  typedef enum logic [1:0] {OFF, RAMP, RUN, STOPPING} state_t;

  state_t      state, state_nxt;
  logic        gen_nxt;
  logic [31:0] tri_nxt, sin_nxt;

  logic        snap_en;
  logic [31:0] snap_tri, snap_sin;
  logic [7:0]  stab_cnt;
  logic        same, accept, cfg_valid;

  logic        en_tgt;
  logic [31:0] tri_tgt, sin_tgt;

  logic [32:0] diff_up, diff_dn, step33;
  logic [31:0] sin_toward, sin_down;

  assign same      = (enable_in == snap_en) && (freq_tri_in == snap_tri) &&
                     (freq_sin_in == snap_sin);
  // Single pulse on the cycle the counter climbs into its saturated value.
  assign accept    = same && (stab_cnt == CNT_PRE);
  assign cfg_valid = (snap_tri != 32'd0) && (snap_sin < snap_tri);

  // Snapshot follows the inputs every cycle, reset included, so held inputs
  // re-qualify right after reset without an extra mismatch cycle.
  always_ff @(posedge clk_clk) begin
    snap_en  <= enable_in;
    snap_tri <= freq_tri_in;
    snap_sin <= freq_sin_in;
  end

  // Stability counter: cleared on any change, saturates at STABLE_CYC-1.
  always_ff @(posedge clk_clk) begin
    if (reset)                     stab_cnt <= '0;
    else if (!same)                stab_cnt <= '0;
    else if (stab_cnt != CNT_MAX)  stab_cnt <= stab_cnt + 8'd1;
  end

  // Targets load on accept; an invalid config keeps old increments but
  // still updates the enable request. A new error wins over err_clr.
  always_ff @(posedge clk_clk) begin
    if (reset) begin
      en_tgt  <= 1'b0;
      tri_tgt <= '0;
      sin_tgt <= '0;
      cfg_err <= 1'b0;
    end else begin
      if (accept) begin
        en_tgt <= snap_en;
        if (cfg_valid) begin
          tri_tgt <= snap_tri;
          sin_tgt <= snap_sin;
        end
      end
      if (accept && !cfg_valid) cfg_err <= 1'b1;
      else if (err_clr)         cfg_err <= 1'b0;
    end
  end

  // Step arithmetic in 33 bits so neither direction can wrap.
  always_comb begin
    step33  = {1'b0, RAMP_STEP};
    diff_up = {1'b0, sin_tgt} - {1'b0, sin_inc};
    diff_dn = {1'b0, sin_inc} - {1'b0, sin_tgt};
    if (sin_tgt >= sin_inc)
      sin_toward = (diff_up <= step33) ? sin_tgt : sin_inc + RAMP_STEP;
    else
      sin_toward = (diff_dn <= step33) ? sin_tgt : sin_inc - RAMP_STEP;
    sin_down = (sin_inc <= RAMP_STEP) ? 32'd0 : sin_inc - RAMP_STEP;
  end

  // Next state and applied increments; increments only move on tri_wrap
  // except when entering or leaving OFF.
  always_comb begin
    state_nxt = state;
    gen_nxt   = gen_enable;
    tri_nxt   = tri_inc;
    sin_nxt   = sin_inc;
    unique case (state)
      OFF: begin
        if (en_tgt && tri_tgt != 32'd0) begin
          state_nxt = RAMP;
          gen_nxt   = 1'b1;
          tri_nxt   = tri_tgt;
          sin_nxt   = '0;
        end
      end
      RAMP: begin
        if (!en_tgt) state_nxt = STOPPING;
        else begin
          if (tri_wrap) begin
            tri_nxt = tri_tgt;
            sin_nxt = sin_toward;
          end
          if (sin_inc == sin_tgt && tri_inc == tri_tgt) state_nxt = RUN;
        end
      end
      RUN: begin
        if (!en_tgt) state_nxt = STOPPING;
        else if (sin_inc != sin_tgt || tri_inc != tri_tgt) state_nxt = RAMP;
      end
      STOPPING: begin
        if (en_tgt) state_nxt = RAMP;
        else if (tri_wrap) begin
          if (sin_inc == 32'd0) begin
            state_nxt = OFF;
            gen_nxt   = 1'b0;
            tri_nxt   = '0;
          end else begin
            sin_nxt = sin_down;
          end
        end
      end
      default: state_nxt = OFF;
    endcase
  end

  // State and output registers; busy is registered alongside the state.
  always_ff @(posedge clk_clk) begin
    if (reset) begin
      state      <= OFF;
      gen_enable <= 1'b0;
      tri_inc    <= '0;
      sin_inc    <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      gen_enable <= gen_nxt;
      tri_inc    <= tri_nxt;
      sin_inc    <= sin_nxt;
      busy       <= (state_nxt == RAMP) || (state_nxt == STOPPING);
    end
  end

endmodule

// File: tb/tb_spwm_param_ctrl.sv
// Bench for spwm_param_ctrl: directed vector table, corner-case sequences
// and a random phase, all checked against a behavioural model.
module tb_spwm_param_ctrl;
  localparam int     SC   = 4;
  localparam longint STEP = 'h100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, enable_in = 1'b0, tri_wrap = 1'b0, err_clr = 1'b0;
  logic [31:0] freq_tri_in = '0, freq_sin_in = '0;
  logic        gen_enable, busy, cfg_err;
  logic [31:0] tri_inc, sin_inc;

  spwm_param_ctrl #(.STABLE_CYC(SC), .RAMP_STEP(32'h100)) dut (
    .clk_clk(clk), .reset(reset), .enable_in(enable_in),
    .freq_tri_in(freq_tri_in), .freq_sin_in(freq_sin_in),
    .tri_wrap(tri_wrap), .err_clr(err_clr), .gen_enable(gen_enable),
    .tri_inc(tri_inc), .sin_inc(sin_inc), .busy(busy), .cfg_err(cfg_err));

  int n_chk = 0, n_fail = 0, cyc = 0;
  bit auto_wrap = 0;

  // Behavioural model: modes 0 off, 1 ramping, 2 running, 3 stopping.
  bit     m_snap_en;
  longint m_snap_tri, m_snap_sin;
  int     m_run;
  bit     m_en_t, m_gen, m_err;
  longint m_tri_t, m_sin_t, m_tri, m_sin;
  int     m_mode;

  function automatic longint approach(longint a, longint t);
    if (t > a) return (t - a <= STEP) ? t : a + STEP;
    return (a - t <= STEP) ? t : a - STEP;
  endfunction

  task automatic model_step();
    bit same, acc, done;
    same = (enable_in == m_snap_en) && (longint'(freq_tri_in) == m_snap_tri) &&
           (longint'(freq_sin_in) == m_snap_sin);
    if (reset) begin
      m_run = 0; m_en_t = 0; m_tri_t = 0; m_sin_t = 0; m_mode = 0;
      m_gen = 0; m_tri = 0; m_sin = 0; m_err = 0;
    end else begin
      acc  = same && (m_run + 1 == SC - 1);
      done = (m_sin == m_sin_t) && (m_tri == m_tri_t);
      case (m_mode)
        0: if (m_en_t && m_tri_t != 0) begin
             m_mode = 1; m_gen = 1; m_tri = m_tri_t; m_sin = 0;
           end
        1: if (!m_en_t) m_mode = 3;
           else begin
             if (tri_wrap) begin m_tri = m_tri_t; m_sin = approach(m_sin, m_sin_t); end
             if (done) m_mode = 2;
           end
        2: if (!m_en_t) m_mode = 3;
           else if (!done) m_mode = 1;
        default: if (m_en_t) m_mode = 1;
           else if (tri_wrap) begin
             if (m_sin == 0) begin m_mode = 0; m_gen = 0; m_tri = 0; end
             else m_sin = (m_sin > STEP) ? m_sin - STEP : 0;
           end
      endcase
      if (acc) begin
        m_en_t = enable_in;
        if (freq_tri_in != 0 && freq_sin_in < freq_tri_in) begin
          m_tri_t = longint'(freq_tri_in); m_sin_t = longint'(freq_sin_in);
        end else m_err = 1;
      end else if (err_clr) m_err = 0;
      m_run = same ? ((m_run < SC - 1) ? m_run + 1 : m_run) : 0;
    end
    m_snap_en = enable_in; m_snap_tri = longint'(freq_tri_in); m_snap_sin = longint'(freq_sin_in);
  endtask

  task automatic check(string name, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock: model advances on the same inputs, DUT sampled 1ns later.
  task automatic tick(input bit cmp = 1'b1);
    if (auto_wrap) tri_wrap = (cyc % 10 == 9);
    model_step();
    @(posedge clk); #1; cyc++;
    if (cmp) begin
      check("gen_enable", longint'(gen_enable), longint'(m_gen));
      check("tri_inc", longint'(tri_inc), m_tri);
      check("sin_inc", longint'(sin_inc), m_sin);
      check("busy", longint'(busy), longint'(m_mode == 1 || m_mode == 3));
      check("cfg_err", longint'(cfg_err), longint'(m_err));
    end
  endtask

  typedef struct {
    bit rst, en; logic [31:0] ftri, fsin; bit wrap, clr;
    bit e_gen; logic [31:0] e_tri, e_sin; bit e_busy, e_err;
  } vec_t;
  vec_t vt[18];

  function automatic vec_t mk(bit rst, bit en, logic [31:0] ft, logic [31:0] fs, bit w, bit c,
                              bit g, logic [31:0] t, logic [31:0] s, bit b, bit e);
    vec_t v;
    v.rst = rst; v.en = en; v.ftri = ft; v.fsin = fs; v.wrap = w; v.clr = c;
    v.e_gen = g; v.e_tri = t; v.e_sin = s; v.e_busy = b; v.e_err = e;
    return v;
  endfunction

  initial begin
    longint q[$];
    longint last;
    int k;
    bit hit;

    // Start-up, stability window, ramp to 250, invalid config, err_clr vs set.
    vt[0]  = mk(1,0,0,0,0,0,     0,0,0,0,0);
    vt[1]  = mk(1,0,0,0,0,0,     0,0,0,0,0);
    vt[2]  = mk(0,1,'h1000,'h250,0,0, 0,0,0,0,0);
    vt[3]  = mk(0,1,'h1000,'h250,0,0, 0,0,0,0,0);
    vt[4]  = mk(0,1,'h1000,'h250,0,0, 0,0,0,0,0);
    vt[5]  = mk(0,1,'h1000,'h250,0,0, 0,0,0,0,0);
    vt[6]  = mk(0,1,'h1000,'h250,0,0, 1,'h1000,0,1,0);
    vt[7]  = mk(0,1,'h1000,'h250,1,0, 1,'h1000,'h100,1,0);
    vt[8]  = mk(0,1,'h1000,'h250,0,0, 1,'h1000,'h100,1,0);
    vt[9]  = mk(0,1,'h1000,'h250,1,0, 1,'h1000,'h200,1,0);
    vt[10] = mk(0,1,'h1000,'h250,1,0, 1,'h1000,'h250,1,0);
    vt[11] = mk(0,1,'h1000,'h250,0,0, 1,'h1000,'h250,0,0);
    vt[12] = mk(0,1,'h1000,'h2000,0,0, 1,'h1000,'h250,0,0);
    vt[13] = mk(0,1,'h1000,'h2000,0,0, 1,'h1000,'h250,0,0);
    vt[14] = mk(0,1,'h1000,'h2000,0,0, 1,'h1000,'h250,0,0);
    vt[15] = mk(0,1,'h1000,'h2000,0,1, 1,'h1000,'h250,0,1);
    vt[16] = mk(0,1,'h1000,'h2000,0,1, 1,'h1000,'h250,0,0);
    vt[17] = mk(0,1,'h1000,'h2000,0,0, 1,'h1000,'h250,0,0);

    #1;
    for (int i = 0; i < 18; i++) begin
      reset = vt[i].rst; enable_in = vt[i].en; freq_tri_in = vt[i].ftri;
      freq_sin_in = vt[i].fsin; tri_wrap = vt[i].wrap; err_clr = vt[i].clr;
      tick(0);
      check($sformatf("vec%0d_gen", i), longint'(gen_enable), longint'(vt[i].e_gen));
      check($sformatf("vec%0d_tri", i), longint'(tri_inc), longint'(vt[i].e_tri));
      check($sformatf("vec%0d_sin", i), longint'(sin_inc), longint'(vt[i].e_sin));
      check($sformatf("vec%0d_busy", i), longint'(busy), longint'(vt[i].e_busy));
      check($sformatf("vec%0d_err", i), longint'(cfg_err), longint'(vt[i].e_err));
    end
    tri_wrap = 0; err_clr = 0;

    // Start with periodic wraps: sin visits 0,100,200,250 then RUN.
    reset = 1; tick(); tick(); reset = 0;
    auto_wrap = 1;
    enable_in = 1; freq_tri_in = 'h1000; freq_sin_in = 'h250;
    last = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (gen_enable && longint'(sin_inc) != last) begin last = sin_inc; q.push_back(last); end
    end
    check("start_steps", q.size(), 4);
    if (q.size() == 4) begin
      check("start_s0", q[0], 0);     check("start_s1", q[1], 'h100);
      check("start_s2", q[2], 'h200); check("start_s3", q[3], 'h250);
    end
    check("start_busy", busy, 0);
    check("start_tri", tri_inc, 'h1000);

    // Invalid config held while running.
    freq_sin_in = 'h2000;
    for (int i = 0; i < 10; i++) tick();
    check("inv_err", cfg_err, 1);
    check("inv_sin", sin_inc, 'h250);
    check("inv_busy", busy, 0);
    err_clr = 1; tick(); err_clr = 0;
    check("inv_clr", cfg_err, 0);
    freq_sin_in = 'h250;
    for (int i = 0; i < 10; i++) tick();

    // Glitch filter: a bad value toggling every 2 cycles is never accepted.
    for (int i = 0; i < 20; i++) begin
      freq_sin_in = ((i / 2) % 2) ? 32'h250 : 32'h2000;
      tick();
    end
    check("glitch_err", cfg_err, 0);
    check("glitch_sin", sin_inc, 'h250);
    check("glitch_busy", busy, 0);
    for (int i = 0; i < 10; i++) tick();

    // Stop, re-arm at 0x150, climb back to 250.
    enable_in = 0; hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin tick(); hit = (sin_inc == 'h150); end
    check("rearm_reach150", hit, 1);
    enable_in = 1; hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin tick(); hit = (busy == 0 && sin_inc == 'h250); end
    check("rearm_back250", hit, 1);
    check("rearm_gen", gen_enable, 1);

    // Full stop: 150, 50, 0, then gen_enable and tri_inc drop together.
    enable_in = 0; q.delete(); last = sin_inc; hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      tick();
      if (longint'(sin_inc) != last) begin last = sin_inc; q.push_back(last); end
      hit = !gen_enable;
    end
    check("stop_off", hit, 1);
    check("stop_tri0", tri_inc, 0);
    check("stop_busy", busy, 0);
    check("stop_steps", q.size(), 3);
    if (q.size() == 3) begin
      check("stop_s0", q[0], 'h150); check("stop_s1", q[1], 'h50); check("stop_s2", q[2], 0);
    end

    // Reset mid-ramp, then held inputs re-trigger after four cycles.
    enable_in = 1; hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin tick(); hit = (sin_inc == 'h100); end
    check("rst_reach100", hit, 1);
    reset = 1; tick();
    check("rst_gen", gen_enable, 0); check("rst_tri", tri_inc, 0);
    check("rst_sin", sin_inc, 0);    check("rst_busy", busy, 0);
    reset = 0; k = 0;
    while (k < 20 && !gen_enable) begin tick(); k++; end
    check("rst_relaunch_cyc", k, 4);
    check("rst_relaunch_sin", sin_inc, 0);
    check("rst_relaunch_tri", tri_inc, 'h1000);

    // Random phase against the model.
    auto_wrap = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0: enable_in = $urandom_range(0, 3) != 0;
          1: case ($urandom_range(0, 5))
               0: freq_tri_in = 0;          1: freq_tri_in = 'h100;
               2: freq_tri_in = 'h800;      3: freq_tri_in = 'h1000;
               4: freq_tri_in = $urandom_range(1, 'hFFFF);
               default: freq_tri_in = 32'hFFFF_FFF0;
             endcase
          default: case ($urandom_range(0, 3))
               0: freq_sin_in = 0;          1: freq_sin_in = $urandom_range(0, 'h1100);
               2: freq_sin_in = 'h250;      default: freq_sin_in = 32'hFFFF_FF00;
             endcase
        endcase
      end
      reset    = ($urandom_range(0, 499) == 0);
      err_clr  = ($urandom_range(0, 19) == 0);
      tri_wrap = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
